// File: rtl/serial_full_subtractor.sv
// rtl/serial_full_subtractor.sv - bit-serial a - b - bin, LSB first, behind a start/busy/done handshake
// Optional macro SERIAL_SUB_OVERFLOW_EN adds the signed-overflow output ovf.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;

    logic w_ai;
    logic w_bi;
    logic w_d;
    logic w_br_next;
    logic w_accept;
    logic w_shift;
    logic w_last;

    assign w_ai      = r_a_sr[0];
    assign w_bi      = r_b_sr[0];
    assign w_d       = w_ai ^ w_bi ^ r_br;
    assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);

    // Counter runs 0..WIDTH: WIDTH bit cycles, then one cycle that publishes the result.
    assign w_accept = start && (r_state != S_SHIFT);
    assign w_shift  = (r_state == S_SHIFT) && (r_cnt != CW'(WIDTH));
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_d_sr <= '0;
            r_diff <= '0;
            r_br   <= 1'b0;
            r_bout <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_br   <= bin;
            r_cnt  <= '0;
        end else if (w_shift) begin
            r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_d_sr <= {w_d, r_d_sr[WIDTH-1:1]};
            r_br   <= w_br_next;
            r_cnt  <= r_cnt + CW'(1);
        end else if (w_last) begin
            r_diff <= r_d_sr;
            r_bout <= r_br;
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_msb_br;
    logic r_ovf;

    // Borrow entering the MSB stage is captured on the last bit cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_msb_br <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_shift && (r_cnt == CW'(WIDTH - 1))) begin
            r_msb_br <= r_br;
        end else if (w_last) begin
            r_ovf <= r_msb_br ^ r_br;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// tb/tb_serial_full_subtractor.sv - randomized and directed bench for serial_full_subtractor (WIDTH 8 and 4)
module tb_serial_full_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_start [2];
    logic [31:0] s_a     [2];
    logic [31:0] s_b     [2];
    logic        s_bin   [2];

    logic       busy8, done8, bout8, ovf8;
    logic       busy4, done4, bout4, ovf4;
    logic [7:0] diff8;
    logic [3:0] diff4;

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    serial_full_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s_start[0]),
        .a     (s_a[0][7:0]),
        .b     (s_b[0][7:0]),
        .bin   (s_bin[0]),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .ovf   (ovf8),
`endif
        .bout  (bout8)
    );

    serial_full_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s_start[1]),
        .a     (s_a[1][3:0]),
        .b     (s_b[1][3:0]),
        .bin   (s_bin[1]),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .ovf   (ovf4),
`endif
        .bout  (bout4)
    );

`ifndef SERIAL_SUB_OVERFLOW_EN
    assign ovf8 = 1'b0;
    assign ovf4 = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference: an accepted operation finishes WIDTH+1 edges later with plain integer arithmetic.
    int          cyc = 0;
    logic        m_active   [2];
    logic        m_done     [2];
    int          m_done_edge[2];
    logic [31:0] m_diff     [2];
    logic        m_bout     [2];
    logic        m_ovf      [2];
    logic [31:0] m_pdiff    [2];
    logic        m_pbout    [2];
    logic        m_povf     [2];

    always @(posedge clk) begin
        int   w, mask, ua, ub, t, sa, sb, st, half;
        logic idle_before;
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            w    = (k == 0) ? 8 : 4;
            mask = (1 << w) - 1;
            half = 1 << (w - 1);
            if (!rst_n) begin
                m_active[k] = 1'b0;
                m_done[k]   = 1'b0;
                m_diff[k]   = '0;
                m_bout[k]   = 1'b0;
                m_ovf[k]    = 1'b0;
            end else begin
                idle_before = !m_active[k];
                m_done[k]   = 1'b0;
                if (m_active[k] && cyc == m_done_edge[k]) begin
                    m_active[k] = 1'b0;
                    m_done[k]   = 1'b1;
                    m_diff[k]   = m_pdiff[k];
                    m_bout[k]   = m_pbout[k];
                    m_ovf[k]    = m_povf[k];
                end
                if (idle_before && s_start[k]) begin
                    ua = int'(s_a[k]) & mask;
                    ub = int'(s_b[k]) & mask;
                    t  = ua - ub - int'(s_bin[k]);
                    sa = (ua >= half) ? ua - (1 << w) : ua;
                    sb = (ub >= half) ? ub - (1 << w) : ub;
                    st = sa - sb - int'(s_bin[k]);
                    m_pdiff[k]     = 32'(t & mask);
                    m_pbout[k]     = (t < 0);
                    m_povf[k]      = (st < -half) || (st > half - 1);
                    m_active[k]    = 1'b1;
                    m_done_edge[k] = cyc + w + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy8", 32'(busy8), 32'(m_active[0]));
            chk("done8", 32'(done8), 32'(m_done[0]));
            chk("diff8", 32'(diff8), m_diff[0]);
            chk("bout8", 32'(bout8), 32'(m_bout[0]));
            chk("busy4", 32'(busy4), 32'(m_active[1]));
            chk("done4", 32'(done4), 32'(m_done[1]));
            chk("diff4", 32'(diff4), m_diff[1]);
            chk("bout4", 32'(bout4), 32'(m_bout[1]));
`ifdef SERIAL_SUB_OVERFLOW_EN
            chk("ovf8", 32'(ovf8), 32'(m_ovf[0]));
            chk("ovf4", 32'(ovf4), 32'(m_ovf[1]));
`endif
        end
    end

    // lat = edges from the accepting edge to the one after which done is seen; returns on the done cycle.
    task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                          input logic binv, output int lat);
        lat = -1;
        @(negedge clk);
        s_start[k] = 1'b1;
        s_a[k]     = av;
        s_b[k]     = bv;
        s_bin[k]   = binv;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (i == 1) begin
                s_start[k] = 1'b0;
                s_a[k]     = $urandom;
                s_b[k]     = $urandom;
                s_bin[k]   = 1'($urandom_range(0, 1));
            end
            if ((k == 0) ? done8 : done4) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs[5] = '{
        '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0},
        '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0},
        '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0},
        '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1},
        '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1}
    };

    initial begin
        int lat, lat2, ndone, drive_i, exp5;
        for (int k = 0; k < 2; k++) begin
            s_start[k] = 1'b0;
            s_a[k]     = '0;
            s_b[k]     = '0;
            s_bin[k]   = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_done", 32'(done8), 32'd0);
        chk("reset_diff", 32'(diff8), 32'd0);
        chk("reset_bout", 32'(bout8), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[v]) begin
            run_op(0, 32'(vecs[v].a), 32'(vecs[v].b), vecs[v].bin, lat);
            chk($sformatf("lat_v%0d", v), 32'(lat), 32'd9);
            chk($sformatf("diff_v%0d", v), 32'(diff8), 32'(vecs[v].diff));
            chk($sformatf("bout_v%0d", v), 32'(bout8), 32'(vecs[v].bout));
`ifdef SERIAL_SUB_OVERFLOW_EN
            chk($sformatf("ovf_v%0d", v), 32'(ovf8), 32'(vecs[v].ovf));
`endif
        end

        // Start while busy is ignored; start on the done cycle chains the next operation.
        @(negedge clk);
        s_start[0] = 1'b1; s_a[0] = 32'h10; s_b[0] = 32'h01; s_bin[0] = 1'b0;
        ndone = 0; lat = -1; lat2 = -1; drive_i = -100;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1 || i == 4 || i == drive_i + 1) s_start[0] = 1'b0;
            if (i == 3) begin
                s_start[0] = 1'b1; s_a[0] = 32'hAA; s_b[0] = 32'h55; s_bin[0] = 1'b1;
            end
            if (done8) begin
                ndone++;
                if (lat < 0) begin
                    lat = i - 1;
                    chk("busy_ignore_diff", 32'(diff8), 32'h0F);
                    chk("busy_ignore_bout", 32'(bout8), 32'd0);
                    s_start[0] = 1'b1; s_a[0] = 32'h33; s_b[0] = 32'h44; s_bin[0] = 1'b1;
                    drive_i = i;
                end else if (lat2 < 0) begin
                    lat2 = i - drive_i - 1;
                    chk("b2b_diff", 32'(diff8), 32'hEE);
                    chk("b2b_bout", 32'(bout8), 32'd1);
                end
            end
        end
        chk("busy_ignore_lat", 32'(lat), 32'd9);
        chk("b2b_lat", 32'(lat2), 32'd9);
        chk("done_count", 32'(ndone), 32'd2);

        // Reset in the middle of SHIFT aborts the operation.
        @(negedge clk);
        s_start[0] = 1'b1; s_a[0] = 32'h5A; s_b[0] = 32'h21; s_bin[0] = 1'b0;
        @(negedge clk);
        s_start[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_diff", 32'(diff8), 32'd0);
        chk("abort_bout", 32'(bout8), 32'd0);
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_op(0, 32'h5A, 32'h21, 1'b0, lat);
        chk("fresh_lat", 32'(lat), 32'd9);
        chk("fresh_diff", 32'(diff8), 32'h39);
        chk("fresh_bout", 32'(bout8), 32'd0);

        // Exhaustive WIDTH=4: {bout, diff} is (a - b - bin) mod 32.
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int c = 0; c < 2; c++) begin
                    run_op(1, 32'(av), 32'(bv), 1'(c), lat);
                    exp5 = (av - bv - c) & 31;
                    chk("w4_lat", 32'(lat), 32'd5);
                    chk("w4_result", {27'd0, bout4, diff4}, 32'(exp5));
                end
            end
        end

        // Random start pulses, including many while busy, on both instances.
        repeat (3000) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                s_start[k] = ($urandom_range(0, 3) == 0);
                s_a[k]     = $urandom;
                s_b[k]     = $urandom;
                s_bin[k]   = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        s_start[0] = 1'b0;
        s_start[1] = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
